// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped UART transmitter.
//   - I/O register addresses (full 16-bit match inside the 2'b11 I/O window)
//   - STATUS register bit positions
//   - 2-bit TX state encoding
package io_pkg;

    localparam logic [15:0] IO_TXDATA  = 16'hC000;
    localparam logic [15:0] IO_STATUS  = 16'hC001;
    localparam logic [15:0] IO_BAUDDIV = 16'hC002;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_BUSY    = 3;
    localparam int ST_CNT_LSB = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: byte-wide synchronous FIFO with first-word-fall-through output.
//   clk      system clock
//   rst      asynchronous active-low reset (pointers and count only)
//   push_i   write din_i (ignored when full unless a pop happens on the same edge)
//   pop_i    drop the head entry (ignored when empty)
//   din_i    byte to write
//   dout_o   current head entry
//   empty_o  no entries
//   full_o   FIFO_DEPTH entries
//   count_o  number of entries, 0..FIFO_DEPTH
module io_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [7:0]                    din_i,
    output logic [7:0]                    dout_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter in the I/O window adr[15:14] == 2'b11.
//   clk        system clock
//   rst        asynchronous active-low reset
//   memwrite   store strobe (one cycle per access)
//   memread    load strobe (one cycle per access)
//   adr        access address (C000 TXDATA, C001 STATUS, C002 BAUDDIV)
//   writedata  store data
//   iodata     registered load data, valid the cycle after memread
//   tx         serial line, idle high
//   irq        high while the FIFO has room and no overflow is pending
module io_uart_tx
    import io_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [15:0] adr,
    input  logic [15:0] writedata,
    output logic [15:0] iodata,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // A zero divisor would never end a bit; clamp it to the fastest legal rate.
    function automatic logic [15:0] div_sat(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    logic          sel, wr_txdata, wr_div, rd_status;
    logic          fifo_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   status;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [15:0] iodata_q, iodata_d;
    logic        tx_q, tx_d;

    assign sel       = (adr[15:14] == 2'b11);
    assign wr_txdata = memwrite && (adr == IO_TXDATA);
    assign wr_div    = memwrite && (adr == IO_BAUDDIV);
    assign rd_status = memread && (adr == IO_STATUS);

    io_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_txdata),
        .pop_i   (fifo_pop),
        .din_i   (writedata[7:0]),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_comb begin
        status               = '0;
        status[ST_EMPTY]     = fifo_empty;
        status[ST_FULL]      = fifo_full;
        status[ST_OVF]       = ovf_q;
        status[ST_BUSY]      = (state_q != S_IDLE);
        status[ST_CNT_LSB +: 4] = 4'(fifo_count);
    end

    // Bit timer: cnt_q counts div-1 .. 0 within each bit; the divisor is only
    // re-read at a bit boundary so a BAUDDIV write never stretches the current bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    cnt_d    = div_q - 16'd1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d    = div_q - 16'd1;
                    bitidx_d = 3'd0;
                    state_d  = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    if (bitidx_q == 3'd7) state_d = S_STOP;
                    else                  bitidx_d = bitidx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin // S_STOP
                if (cnt_q == 16'd0) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        cnt_d    = div_q - 16'd1;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // tx is registered from the next state so the line is glitch-free.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bitidx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        div_d = wr_div ? div_sat(writedata) : div_q;
        // Setting wins over a same-edge STATUS read so a fresh overflow is not lost.
        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
        else if (rd_status)                      ovf_d = 1'b0;
        else                                     ovf_d = ovf_q;
        iodata_d = iodata_q;
        if (memread && sel) begin
            case (adr)
                IO_STATUS:  iodata_d = status;
                IO_BAUDDIV: iodata_d = div_q;
                default:    iodata_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            div_q    <= DEFAULT_DIV;
            ovf_q    <= 1'b0;
            iodata_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            iodata_q <= iodata_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign iodata = iodata_q;
    assign tx     = tx_q;
    assign irq    = !fifo_full && !ovf_q;

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwrite, memread;
    logic [15:0] adr, writedata;
    logic [15:0] iodata;
    logic        tx, irq;

    int checks = 0;
    int errors = 0;

    io_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .memread   (memread),
        .adr       (adr),
        .writedata (writedata),
        .iodata    (iodata),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] adr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // 8N1 frame bit k (0 = start, 1..8 = data LSB first, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    // Bus tasks start at a negedge and return at the next negedge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        memwrite = 1'b1; adr = a; writedata = d;
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        memread = 1'b1; adr = a;
        @(negedge clk);
        memread = 1'b0;
        v = iodata;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check_bit("reset_tx_async", tx, 1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  tri_b [3];
        tri_b[0] = 8'h01; tri_b[1] = 8'h02; tri_b[2] = 8'h03;

        vecs[0]  = '{1'b1, 1'b0, 16'hC001, 16'h0000, 1'b1, 16'h0001};
        vecs[1]  = '{1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 16'h01B2};
        vecs[2]  = '{1'b1, 1'b0, 16'h8002, 16'h0000, 1'b1, 16'h01B2};
        vecs[3]  = '{1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 16'h0001};
        vecs[6]  = '{1'b1, 1'b1, 16'hC002, 16'h1234, 1'b1, 16'h0001};
        vecs[7]  = '{1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 16'h1234};
        vecs[8]  = '{1'b0, 1'b1, 16'hC003, 16'hFFFF, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 16'h4002, 16'h5555, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 16'h1234};
        vecs[11] = '{1'b1, 1'b0, 16'hC003, 16'h0000, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 16'hC002, 16'h0004, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'hC002, 16'h0000, 1'b1, 16'h0004};
        vecs[14] = '{1'b1, 1'b0, 16'hC001, 16'h0000, 1'b1, 16'h0001};

        rst = 1'b0; memwrite = 1'b0; memread = 1'b0; adr = '0; writedata = '0;
        repeat (3) @(negedge clk);
        check_bit("reset_tx", tx, 1'b1);
        check("reset_iodata", iodata, 16'h0000);
        check_bit("reset_irq", irq, 1'b1);
        rst = 1'b1;

        // Register map vectors
        for (int i = 0; i < 15; i++) begin
            memread = vecs[i].rd; memwrite = vecs[i].wr;
            adr = vecs[i].adr; writedata = vecs[i].wdata;
            @(negedge clk);
            memread = 1'b0; memwrite = 1'b0;
            if (vecs[i].chk) check($sformatf("vec%0d", i), iodata, vecs[i].exp);
        end

        // Single frame A5 at 4 clocks per bit
        memwrite = 1'b1; adr = 16'hC000; writedata = 16'h00A5;
        @(negedge clk);
        memwrite = 1'b0;
        check_bit("a5_pre_idle", tx, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check_bit($sformatf("a5_clk%0d", k), tx, frame_bit(8'hA5, k / 4));
        end
        @(negedge clk);
        check_bit("a5_post_idle", tx, 1'b1);
        rd(16'hC001, v);
        check("a5_status_idle", v, 16'h0001);

        // Three contiguous frames
        memwrite = 1'b1; adr = 16'hC000; writedata = 16'h0001;
        for (int c = 1; c <= 122; c++) begin
            @(negedge clk);
            case (c)
                1:   writedata = 16'h0002;
                2:   writedata = 16'h0003;
                3:   memwrite = 1'b0;
                4:   begin memread = 1'b1; adr = 16'hC001; end
                5:   begin memread = 1'b0; check("tri_status_c5", iodata, 16'h0028); end
                60:  begin memread = 1'b1; adr = 16'hC001; end
                61:  begin memread = 1'b0; check("tri_status_c61", iodata, 16'h0018); end
                100: begin memread = 1'b1; adr = 16'hC001; end
                101: begin memread = 1'b0; check("tri_status_c101", iodata, 16'h0009); end
                default: ;
            endcase
            if (c >= 2 && c <= 121)
                check_bit($sformatf("tri_clk%0d", c), tx,
                          frame_bit(tri_b[(c - 2) / 40], ((c - 2) % 40) / 4));
            if (c == 122) check_bit("tri_idle", tx, 1'b1);
        end
        rd(16'hC001, v);
        check("tri_status_end", v, 16'h0001);

        // Overflow with a slow divisor
        wr(16'hC002, 16'd1000);
        for (int i = 0; i < 6; i++) wr(16'hC000, 16'h0010 + 16'(i));
        check_bit("ovf_irq_low", irq, 1'b0);
        rd(16'hC001, v);
        check("ovf_status_first", v, 16'h004E);
        rd(16'hC001, v);
        check("ovf_status_cleared", v, 16'h004A);
        check_bit("ovf_irq_full", irq, 1'b0);
        pulse_reset();
        rd(16'hC001, v);
        check("ovf_flush_status", v, 16'h0001);
        check_bit("ovf_flush_irq", irq, 1'b1);

        // Divisor change mid-frame: start bit keeps 4, data bits use 8
        wr(16'hC002, 16'h0004);
        memwrite = 1'b1; adr = 16'hC000; writedata = 16'h0055;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            case (c)
                1: memwrite = 1'b0;
                3: begin memwrite = 1'b1; adr = 16'hC002; writedata = 16'h0008; end
                4: memwrite = 1'b0;
                default: ;
            endcase
            if (c >= 2)
                check_bit($sformatf("div_clk%0d", c), tx,
                          (c < 6) ? 1'b0 : frame_bit(8'h55, 1 + (c - 6) / 8));
        end
        pulse_reset();

        // Reset during data bit 3
        wr(16'hC002, 16'h0004);
        memwrite = 1'b1; adr = 16'hC000; writedata = 16'h0007;
        @(negedge clk);
        memwrite = 1'b0;
        for (int c = 2; c <= 19; c++) @(negedge clk);
        check_bit("midrst_bit3_low", tx, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_bit("midrst_tx_async", tx, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        check("midrst_iodata", iodata, 16'h0000);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check_bit($sformatf("midrst_quiet%0d", c), tx, 1'b1);
        end
        rd(16'hC001, v);
        check("midrst_status", v, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
